// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings and helpers for the memory responder
package mem_resp_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Size code 2'b11 behaves as a word access everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: misaligned = off[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - req/ack memory bus between initiator and responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (output req, we, addr, wdata, size, input ack, rdata, busy, err);
  modport slave  (input req, we, addr, wdata, size, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_resp_lane.sv
// rtl/mem_resp_lane.sv - little-endian lane select/merge shared by read and write paths
module mem_resp_lane
  import mem_resp_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] merged_o,
  output logic [31:0] rd_o
);

  logic [4:0] half_sh;
  logic [4:0] byte_sh;

  assign half_sh = {byte_off_i[1], 4'b0000};
  assign byte_sh = {byte_off_i, 3'b000};

  always_comb begin
    merged_o = word_i;
    rd_o     = word_i;
    case (size_i)
      SZ_HALF: begin
        merged_o[half_sh +: 16] = wdata_i[15:0];
        rd_o = {16'h0000, word_i[half_sh +: 16]};
      end
      SZ_BYTE: begin
        merged_o[byte_sh +: 8] = wdata_i[7:0];
        rd_o = {24'h000000, word_i[byte_sh +: 8]};
      end
      default: begin
        merged_o = wdata_i;
        rd_o     = word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with wait states over a word RAM
// Optional access-error checking is enabled by defining MEM_RESP_ERR_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem_word;
  logic [31:0]           merged;
  logic [31:0]           rd_val;
  logic                  ram_we;
  logic                  acc_err;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign mem_word = mem[idx];

  mem_resp_lane u_lane (
    .word_i     (mem_word),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .byte_off_i (addr_q[1:0]),
    .merged_o   (merged),
    .rd_o       (rd_val)
  );

`ifdef MEM_RESP_ERR_EN
  assign acc_err = misaligned(size_q, addr_q[1:0]) || (addr_q[31:DEPTH_LOG2+2] != '0);
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          size_d  = bus.size;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          err_d   = acc_err;
          if (acc_err) begin
            rdata_d = 32'h0;
          end else begin
            rdata_d = we_q ? merged : rd_val;
            ram_we  = we_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= SZ_WORD;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never reset; a reset forces ST_IDLE so an aborted write cannot land.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= merged;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] ackv, busyv;
  logic [31:0] got_rd;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance and watch 7 cycles; inputs
  // are scrambled right after acceptance to show they are not re-sampled.
  task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d; b2.size = sz;
    ackv = '0; busyv = '0; got_rd = 32'hxxxxxxxx; got_err = 1'bx;
    for (int c = 1; c <= 7; c++) begin
      tick();
      b2.req = 1'b0; b2.we = ~w; b2.addr = a ^ 32'h4; b2.wdata = ~d; b2.size = sz ^ 2'b10;
      ackv[c]  = b2.ack;
      busyv[c] = b2.busy;
      if (b2.ack) begin
        got_rd  = b2.rdata;
        got_err = b2.err;
      end
    end
  endtask

  initial begin
    int n_ack;
    logic [31:0] last_rd;

    b2.req = 0; b2.we = 0; b2.addr = 0; b2.wdata = 0; b2.size = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0; b0.size = 0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b2.busy), 32'h0);
    reset = 1'b1;
    tick();
    chk("rst_ack", 32'(b2.ack), 32'h0);
    chk("rst_rdata", b2.rdata, 32'h0);
    chk("rst_err", 32'(b2.err), 32'h0);
    chk("rst_busy0", 32'(b0.busy), 32'h0);
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b2.ack || b0.ack) n_ack++;
    end
    chk("idle_acks", 32'(n_ack), 32'h0);

    txn2(1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    chk("wr_ack_cycles", 32'(ackv), 32'h0010);
    chk("wr_busy_cycles", 32'(busyv), 32'h001E);
    chk("wr_post_word", got_rd, 32'hDEADBEEF);
    chk("wr_err", 32'(got_err), 32'h0);

    txn2(1'b0, 32'h10, 32'h0, 2'b00);
    chk("rd_ack_cycles", 32'(ackv), 32'h0010);
    chk("rd_word", got_rd, 32'hDEADBEEF);
    chk("rd_held", b2.rdata, 32'hDEADBEEF);

    txn2(1'b1, 32'h11, 32'h000000AA, 2'b10);
    chk("wb_post_word", got_rd, 32'hDEADAAEF);
    txn2(1'b0, 32'h10, 32'h0, 2'b00);
    chk("wb_read_word", got_rd, 32'hDEADAAEF);

    txn2(1'b1, 32'h12, 32'h00001234, 2'b01);
    chk("wh_post_word", got_rd, 32'h1234AAEF);
    txn2(1'b0, 32'h10, 32'h0, 2'b00);
    chk("wh_read_word", got_rd, 32'h1234AAEF);

    txn2(1'b0, 32'h13, 32'h0, 2'b10);
    chk("rb_lane3", got_rd, 32'h00000012);
    txn2(1'b0, 32'h10, 32'h0, 2'b10);
    chk("rb_lane0", got_rd, 32'h000000EF);
    txn2(1'b0, 32'h10, 32'h0, 2'b01);
    chk("rh_lane0", got_rd, 32'h0000AAEF);
    txn2(1'b0, 32'h10, 32'h0, 2'b11);
    chk("rsz11_word", got_rd, 32'h1234AAEF);

    // WAIT_CYCLES=0: req high cycles 0..8, wdata flipped only during WAIT cycles.
    b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h30; b0.wdata = 32'h600DCAFE; b0.size = 2'b00;
    ackv = '0; last_rd = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 9) b0.req = 1'b0;
      b0.wdata = (c % 3 == 1) ? 32'hBAADBAAD : 32'h600DCAFE;
      ackv[c] = b0.ack;
      if (b0.ack) last_rd = b0.rdata;
    end
    chk("busy_ack_cycles", 32'(ackv), 32'h0124);
    chk("busy_wdata_ignored", last_rd, 32'h600DCAFE);

    txn2(1'b1, 32'h20, 32'hCAFEF00D, 2'b00);
    chk("pre_wr20", got_rd, 32'hCAFEF00D);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h20; b2.wdata = 32'h55; b2.size = 2'b00;
    tick();
    b2.req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(b2.busy), 32'h0);
    chk("abort_rdata", b2.rdata, 32'h0);
    tick();
    reset = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (b2.ack) n_ack++;
    end
    chk("abort_no_ack", 32'(n_ack), 32'h0);
    txn2(1'b0, 32'h20, 32'h0, 2'b00);
    chk("abort_ram_kept", got_rd, 32'hCAFEF00D);

    txn2(1'b1, 32'h0, 32'h01020304, 2'b00);
    chk("wr_word0", got_rd, 32'h01020304);
`ifdef MEM_RESP_ERR_EN
    txn2(1'b0, 32'h22, 32'h0, 2'b00);
    chk("err_mis_ack", 32'(ackv), 32'h0010);
    chk("err_mis_flag", 32'(got_err), 32'h1);
    chk("err_mis_rdata", got_rd, 32'h0);
    txn2(1'b1, 32'h400, 32'h0BADF00D, 2'b00);
    chk("err_oob_flag", 32'(got_err), 32'h1);
    chk("err_oob_rdata", got_rd, 32'h0);
    txn2(1'b0, 32'h0, 32'h0, 2'b00);
    chk("err_oob_word0", got_rd, 32'h01020304);
    chk("err_ok_flag", 32'(got_err), 32'h0);
`else
    txn2(1'b0, 32'h22, 32'h0, 2'b00);
    chk("noerr_mis_flag", 32'(got_err), 32'h0);
    chk("noerr_mis_aligned", got_rd, 32'hCAFEF00D);
    txn2(1'b1, 32'h400, 32'h0BADF00D, 2'b00);
    chk("noerr_oob_flag", 32'(got_err), 32'h0);
    txn2(1'b0, 32'h0, 32'h0, 2'b00);
    chk("noerr_alias_word0", got_rd, 32'h0BADF00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
